// File: rtl/mem_req_master_pkg.sv
// Shared types and widths for the memory request master and its command FIFO.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_req_master_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_req_master_if.sv
// Command, response and memory-side signals of the memory request master.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = requester block, slave = its environment.
interface mem_req_master_if;
    import mem_req_master_pkg::*;

    // command port
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_rnw_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    // response port
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_rnw_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    // memory port
    logic              mem_req_o;
    logic              mem_rnw_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (
        input  cmd_valid_i, cmd_rnw_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i, mem_ready_i, mem_rdata_i,
        output cmd_ready_o, rsp_valid_o, rsp_rnw_o, rsp_rdata_o, rsp_err_o,
        output mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_rnw_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i, mem_ready_i, mem_rdata_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rnw_o, rsp_rdata_o, rsp_err_o,
        input  mem_req_o, mem_rnw_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_cmd_fifo.sv
// Synchronous FIFO of mem_cmd_t; pop_dat shows the head combinationally.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, reset (async active-low), push/push_dat, pop/pop_dat, full, empty.
module mem_cmd_fifo
    import mem_req_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  mem_cmd_t push_dat,
    input  logic     pop,
    output mem_cmd_t pop_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    mem_cmd_t    store [DEPTH];
    // one extra wrap bit separates full from empty when the indices match
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign pop_dat = store[rd_ptr[AW-1:0]];
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/mem_req_master.sv
// Queues read/write commands and drives one level-held memory request at a time.
// Latency: push -> mem_req_o after 1 idle cycle; 3-cycle minimum command spacing.
// Backpressure: cmd_ready_o = !full; a new request waits until the response slot frees.
// Ports: clk, reset (async active-low), bus (mem_req_master_if.master: cmd, rsp, mem).
// Optional MEM_REQ_MASTER_TIMEOUT_EN: abort a request after TIMEOUT cycles without ready.
module mem_req_master
    import mem_req_master_pkg::*;
#(
    parameter int ADDR_W    = mem_req_master_pkg::ADDR_W,
    parameter int DATA_W    = mem_req_master_pkg::DATA_W,
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    parameter int TIMEOUT   = 32,
`endif
    parameter int CMD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_req_master_if.master   bus
);

    state_t            state;
    state_t            state_nxt;
    mem_cmd_t          cmd_in;
    mem_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              done;
    logic              finish;
    logic              rsp_free;
    logic              ready_en;

    logic              mem_rnw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rsp_valid_q;
    logic              rsp_rnw_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;
    logic       abort;
    logic       rsp_err_q;
`endif

    // Keeps cmd_ready_o low during reset and until the first clock after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    assign bus.cmd_ready_o = ready_en & ~fifo_full;
    assign push            = bus.cmd_valid_i & bus.cmd_ready_o;
    assign cmd_in          = '{rnw: bus.cmd_rnw_i, addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i};

    mem_cmd_fifo #(
        .DEPTH    (CMD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (cmd_in),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // The slot counts as free when the current response is accepted this cycle.
    assign rsp_free = ~rsp_valid_q | bus.rsp_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        done      = 1'b0;
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        abort     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty && rsp_free) begin
                    pop       = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // ready wins over a timeout landing in the same cycle
                if (bus.mem_ready_i) begin
                    done      = 1'b1;
                    state_nxt = GAP;
                end
`ifdef MEM_REQ_MASTER_TIMEOUT_EN
                else if (wait_cnt == TO_LAST) begin
                    abort     = 1'b1;
                    state_nxt = GAP;
                end
`endif
            end
            // request low for one cycle so the memory sees a fresh rising edge
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
    assign finish = done | abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                  wait_cnt <= '0;
        else if (pop)                                wait_cnt <= '0;
        else if (state == REQ && !bus.mem_ready_i)   wait_cnt <= wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      rsp_err_q <= 1'b0;
        else if (finish) rsp_err_q <= abort;
    end

    assign bus.rsp_err_o = rsp_err_q;
`else
    assign finish        = done;
    assign bus.rsp_err_o = 1'b0;
`endif

    // Memory-side registers load only on pop, so they hold through REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rnw_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (pop) begin
            mem_rnw_q   <= head.rnw;
            mem_addr_q  <= head.addr;
            mem_wdata_q <= head.wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rnw_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (finish) begin
            rsp_valid_q <= 1'b1;
            rsp_rnw_q   <= mem_rnw_q;
            rsp_rdata_q <= (mem_rnw_q && done) ? bus.mem_rdata_i : '0;
        end else if (rsp_valid_q && bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.mem_req_o   = (state == REQ);
    assign bus.mem_rnw_o   = mem_rnw_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rnw_o   = rsp_rnw_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a random-latency-style memory model.
// Latency: model asserts mem_ready_i on REQ cycle 'lat' (lat=0: never).
// Backpressure: rsp_ready_i driven directly by the stimulus.
module tb_mem_req_master;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // memory model
    int          lat;
    int          req_cnt;
    logic [31:0] mem_model [16];

    // test 4 observations
    logic        seen_rnw [5];
    logic [31:0] seen_dat [5];
    int          n_rsp;
    int          rise_cyc [8];
    int          n_rise;
    logic        prev_req;

    int          req_cycles;
    logic        stable;
    logic        hold_ok;
    logic [31:0] cap_dat;

    mem_req_master_if bus ();

    mem_req_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_ready_i = bus.mem_req_o && (lat != 0) && (req_cnt >= lat - 1);
    assign bus.mem_rdata_i = mem_model[bus.mem_addr_o];

    always @(posedge clk) begin
        if (bus.mem_req_o && bus.mem_ready_i && !bus.mem_rnw_o)
            mem_model[bus.mem_addr_o] <= bus.mem_wdata_o;
        if (bus.mem_req_o && !bus.mem_ready_i) req_cnt <= req_cnt + 1;
        else                                   req_cnt <= 0;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one command and hold it until accepted (bounded wait).
    task automatic push_cmd(input logic rnw, input logic [3:0] a, input logic [31:0] d);
        int w;
        w = 0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_rnw_i   = rnw;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        @(negedge clk);
        while (!bus.cmd_ready_o && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("push_ready", 64'(bus.cmd_ready_o), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    // Wait for a request, count its width and watch its outputs; returns in the GAP cycle.
    task automatic run_txn(output int cycles, output logic stab);
        int          w;
        logic        r;
        logic [3:0]  a;
        logic [31:0] d;
        w      = 0;
        cycles = 0;
        stab   = 1'b1;
        @(negedge clk);
        while (!bus.mem_req_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        r = bus.mem_rnw_o;
        a = bus.mem_addr_o;
        d = bus.mem_wdata_o;
        while (bus.mem_req_o && cycles < 200) begin
            cycles++;
            if (bus.mem_rnw_o !== r || bus.mem_addr_o !== a || bus.mem_wdata_o !== d) stab = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic accept_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        lat             = 1;
        reset           = 1'b0;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_rnw_i   = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;

        // 1: reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        check_eq("rst_mem_req",   64'(bus.mem_req_o),   64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check_eq("rst_mem_addr",  64'(bus.mem_addr_o),  64'd0);
        check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        check_eq("rst_rsp_err",   64'(bus.rsp_err_o),   64'd0);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        bus.cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("post_rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        repeat (2) @(negedge clk);
        check_eq("post_rst_no_req", 64'(bus.mem_req_o), 64'd0);
        @(posedge clk);
        #1;

        // 2: write, ready on REQ cycle 5
        lat = 5;
        push_cmd(1'b0, 4'd3, 32'hDEADBEEF);
        run_txn(req_cycles, stable);
        check_eq("wr_req_width", 64'(req_cycles), 64'd5);
        check_eq("wr_stable",    64'(stable),     64'd1);
        check_eq("wr_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check_eq("wr_rsp_rnw",   64'(bus.rsp_rnw_o),   64'd0);
        check_eq("wr_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        accept_rsp();

        // 3: read back, ready on first REQ cycle
        lat = 1;
        push_cmd(1'b1, 4'd3, 32'h0);
        run_txn(req_cycles, stable);
        check_eq("rd_req_width", 64'(req_cycles), 64'd1);
        check_eq("rd_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check_eq("rd_rsp_rnw",   64'(bus.rsp_rnw_o),   64'd1);
        check_eq("rd_rsp_rdata", 64'(bus.rsp_rdata_o), 64'hDEADBEEF);
        accept_rsp();

        // 4: five back-to-back commands with the memory stalled
        lat             = 0;
        bus.rsp_ready_i = 1'b1;
        push_cmd(1'b0, 4'd5, 32'h11111111);
        push_cmd(1'b1, 4'd5, 32'h0);
        push_cmd(1'b0, 4'd6, 32'h22222222);
        push_cmd(1'b1, 4'd6, 32'h0);
        push_cmd(1'b1, 4'd3, 32'h0);
        @(negedge clk);
        check_eq("full_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
        check_eq("full_mem_req",   64'(bus.mem_req_o),   64'd1);
        check_eq("full_mem_addr",  64'(bus.mem_addr_o),  64'd5);
        @(posedge clk);
        #1;
        lat      = 1;
        n_rsp    = 0;
        n_rise   = 0;
        prev_req = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid_o && n_rsp < 5) begin
                seen_rnw[n_rsp] = bus.rsp_rnw_o;
                seen_dat[n_rsp] = bus.rsp_rdata_o;
                n_rsp++;
            end
            if (bus.mem_req_o && !prev_req && n_rise < 8) begin
                rise_cyc[n_rise] = cyc;
                n_rise++;
            end
            prev_req = bus.mem_req_o;
        end
        check_eq("ord_count", 64'(n_rsp),  64'd5);
        check_eq("ord_rises", 64'(n_rise), 64'd4);
        if (n_rise >= 2) check_eq("ord_spacing", 64'(rise_cyc[1] - rise_cyc[0]), 64'd3);
        if (n_rsp == 5) begin
            check_eq("ord0_rnw", 64'(seen_rnw[0]), 64'd0);
            check_eq("ord0_dat", 64'(seen_dat[0]), 64'd0);
            check_eq("ord1_rnw", 64'(seen_rnw[1]), 64'd1);
            check_eq("ord1_dat", 64'(seen_dat[1]), 64'h11111111);
            check_eq("ord2_rnw", 64'(seen_rnw[2]), 64'd0);
            check_eq("ord2_dat", 64'(seen_dat[2]), 64'd0);
            check_eq("ord3_rnw", 64'(seen_rnw[3]), 64'd1);
            check_eq("ord3_dat", 64'(seen_dat[3]), 64'h22222222);
            check_eq("ord4_rnw", 64'(seen_rnw[4]), 64'd1);
            check_eq("ord4_dat", 64'(seen_dat[4]), 64'hDEADBEEF);
        end
        @(posedge clk);
        #1;

        // 5: response backpressure blocks the next request
        bus.rsp_ready_i = 1'b0;
        push_cmd(1'b1, 4'd5, 32'h0);
        push_cmd(1'b1, 4'd6, 32'h0);
        repeat (3) @(negedge clk);
        check_eq("bp_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check_eq("bp_rsp_rdata", 64'(bus.rsp_rdata_o), 64'h11111111);
        cap_dat = bus.rsp_rdata_o;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.mem_req_o || !bus.rsp_valid_o || bus.rsp_rdata_o !== cap_dat || !bus.rsp_rnw_o)
                hold_ok = 1'b0;
        end
        check_eq("bp_hold", 64'(hold_ok), 64'd1);
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        check_eq("bp_req_start",  64'(bus.mem_req_o),   64'd1);
        check_eq("bp_req_addr",   64'(bus.mem_addr_o),  64'd6);
        check_eq("bp_rsp_clear",  64'(bus.rsp_valid_o), 64'd0);
        @(negedge clk);
        check_eq("bp2_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check_eq("bp2_rsp_rdata", 64'(bus.rsp_rdata_o), 64'h22222222);
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;

`ifdef MEM_REQ_MASTER_TIMEOUT_EN
        // 6: timeout with the memory stuck not-ready
        lat = 0;
        push_cmd(1'b0, 4'd9, 32'h33333333);
        run_txn(req_cycles, stable);
        check_eq("to_req_width", 64'(req_cycles),       64'd32);
        check_eq("to_rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
        check_eq("to_rsp_err",   64'(bus.rsp_err_o),   64'd1);
        check_eq("to_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        accept_rsp();
        lat = 1;
        push_cmd(1'b1, 4'd5, 32'h0);
        run_txn(req_cycles, stable);
        check_eq("to_next_width", 64'(req_cycles),       64'd1);
        check_eq("to_next_err",   64'(bus.rsp_err_o),   64'd0);
        check_eq("to_next_rdata", 64'(bus.rsp_rdata_o), 64'h11111111);
        accept_rsp();
`endif

        // reset in the middle of a request
        lat = 0;
        push_cmd(1'b0, 4'd2, 32'h44444444);
        repeat (2) @(negedge clk);
        check_eq("mid_req_high", 64'(bus.mem_req_o), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_req",   64'(bus.mem_req_o),   64'd0);
        check_eq("mid_rst_ready", 64'(bus.cmd_ready_o), 64'd0);
        check_eq("mid_rst_rsp",   64'(bus.rsp_valid_o), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        lat   = 1;
        repeat (4) @(negedge clk);
        check_eq("mid_discard_req", 64'(bus.mem_req_o),   64'd0);
        check_eq("mid_ready_back",  64'(bus.cmd_ready_o), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_master.md
Name: mem_req_master

Overview:
- Upstream requester for the 16-entry random-latency memory interface stage.
- Accepts read/write commands over a valid/ready port, buffers them in a small command FIFO, and drives one level-held memory request at a time. The request is held until the memory signals ready.
- Returns one response per command (read data or write ack) over a valid/ready port.
- Forces a one-cycle request-low gap between transactions so the memory's rising-edge latency generator re-arms.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 32, data width.
- CMD_DEPTH, 4, command FIFO entries (power of 2, >=2).
- TIMEOUT, 32, REQ-state cycle limit (used only with the optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  FIFO can accept
- cmd_rnw_i  input  1  1=read, 0=write
- cmd_addr_i  input  ADDR_W  command address
- cmd_wdata_i  input  DATA_W  write data
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  response consumer ready
- rsp_rnw_o  output  1  echo of command rnw
- rsp_rdata_o  output  DATA_W  read data (0 for writes)
- rsp_err_o  output  1  timeout error (constant 0 without the optional feature)
- mem_req_o  output  1  memory request, level
- mem_rnw_o  output  1  memory read/not-write
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_ready_i  input  1  memory ready
- mem_rdata_i  input  DATA_W  memory read data (combinational from memory)

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-low. While reset=0:
  - FIFO is empty; state=IDLE.
  - mem_req_o=0, mem_rnw_o=0, mem_addr_o=0, mem_wdata_o=0.
  - rsp_valid_o=0, rsp_rnw_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - cmd_ready_o=1 after reset releases.
- Command push: a command is pushed when cmd_valid_i & cmd_ready_o. cmd_ready_o = !full. A push is blocked when the FIFO is full, even if a pop happens in the same cycle.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - Transition to REQ when the FIFO is non-empty and the response slot is free (rsp_valid_o=0, or rsp_valid_o & rsp_ready_i this cycle).
  - On that transition, pop the FIFO head into the mem_rnw/addr/wdata output registers.
- REQ:
  - mem_req_o=1; the mem_* outputs are stable for the whole state.
  - The transaction completes in any cycle where mem_ready_i=1, including the first REQ cycle.
  - On completion: rsp_valid_o<=1, rsp_rnw_o<=mem_rnw_o, rsp_rdata_o<=(mem_rnw_o ? mem_rdata_i : 0), rsp_err_o<=0; next state is GAP.
- GAP:
  - mem_req_o=0 for exactly one cycle, then IDLE.
  - Minimum command-to-command spacing is 3 cycles (IDLE, REQ, GAP) when the memory is ready on the first REQ cycle.
- Response slot:
  - Single register. Cleared on rsp_valid_o & rsp_ready_i.
  - Outputs are held stable while rsp_valid_o=1 and rsp_ready_i=0.
- Ordering: responses are strictly in command order; only one transaction is outstanding.
- FIFO pointers: ADDR of log2(CMD_DEPTH) bits plus one wrap bit. full = pointers equal except the wrap bit; empty = pointers fully equal.
- Reset mid-transaction: mem_req_o drops immediately (asynchronous). The pending command and response are discarded.

Optional Feature:
- Macro: MEM_REQ_MASTER_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit wait counter clears on entry to REQ and increments on each REQ cycle without mem_ready_i.
  - When the counter reaches TIMEOUT-1 with mem_ready_i=0, the transaction aborts: rsp_valid_o<=1, rsp_err_o<=1, rsp_rdata_o<=0; next state is GAP.
  - mem_ready_i=1 in the same cycle takes priority, giving a normal completion.
- Without the macro: no counter exists, REQ waits indefinitely, and rsp_err_o is tied to 0.

Decomposition:
- Package mem_req_master_pkg contains:
  - state_t enum {IDLE, REQ, GAP}.
  - mem_cmd_t struct {rnw, addr, wdata}, sized by the package constants ADDR_W=4 and DATA_W=32.
- One sub-module: mem_cmd_fifo, a synchronous FIFO of mem_cmd_t with push/pop/full/empty, depth CMD_DEPTH, same clock and reset.

Test Plan:
1. Reset held low with cmd_valid_i=1 -> cmd_ready_o, mem_req_o and rsp_valid_o all 0; after release, cmd_ready_o=1 and the FIFO is empty.
2. Write addr=3, wdata=0xDEADBEEF; model drives mem_ready_i high on REQ cycle 5 -> mem_req_o high for exactly 5 cycles with stable outputs, then 1 gap cycle; rsp_valid_o=1, rsp_rnw_o=0, rsp_rdata_o=0.
3. Read addr=3 after test 2; model returns 0xDEADBEEF with mem_ready_i on the first REQ cycle -> rsp_rdata_o=0xDEADBEEF one cycle later; mem_req_o pulse is 1 cycle wide, followed by the 1-cycle gap.
4. Push 5 commands back-to-back with mem_ready_i=0 -> cmd_ready_o drops after the FIFO fills (4 entries while the first is in REQ); all 5 responses arrive in order once ready is given.
5. Hold rsp_ready_i=0 for 10 cycles with 2 queued reads -> second REQ does not start; rsp outputs are stable; the second REQ starts in the cycle the first response is accepted.
6. With MEM_REQ_MASTER_TIMEOUT_EN, TIMEOUT=32, mem_ready_i stuck 0 -> after 32 REQ cycles: rsp_err_o=1, rsp_rdata_o=0, then GAP; the next command proceeds normally.
